// File: rtl/gate_test_sequencer.sv
// Purpose : clocked self-checking sequencer for a 2-input combinational gate under test;
//           walks vectors 00,01,10,11, holds each SETTLE+1 cycles, samples dut_y and
//           compares against truth table TT (bit index = {a,b}).
// Latency : done pulses in the cycle after edge E0+4*(SETTLE+1) when start is accepted at E0.
// Backpr. : none; start is honoured only in IDLE, abort cancels a run in SETTLE/CHECK.
// Ports   : clk/rst (async active-high), start/abort from the harness, dut_y from the gate,
//           dut_a/dut_b to the gate, exp_y/vec_idx/busy/done/pass/err_count/fail_mask status.
module gate_test_sequencer #(
    parameter logic [3:0] TT     = 4'b1000,
    parameter int         SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       exp_y,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       mismatch;
    logic [2:0] err_next;

    assign exp_y    = TT[{dut_a, dut_b}];
    assign busy     = (state == S_SETTLE) || (state == S_CHECK);
    assign done     = (state == S_DONE);
    assign mismatch = (state == S_CHECK) && (dut_y != TT[vec_idx]);
    // At most four CHECK cycles per run, so the 3-bit count never wraps.
    assign err_next = err_count + {2'b00, mismatch};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            vec_idx   <= 2'd0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count <= 3'd0;
                        fail_mask <= 4'd0;
                        pass      <= 1'b0;
                        vec_idx   <= 2'd0;
                        dut_a     <= 1'b0;
                        dut_b     <= 1'b0;
                        cnt       <= CNT_LOAD;
                        state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        pass    <= 1'b0;
                        vec_idx <= 2'd0;
                        dut_a   <= 1'b0;
                        dut_b   <= 1'b0;
                        cnt     <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    // A mismatch is recorded even if this cycle is also aborted.
                    if (mismatch) begin
                        err_count          <= err_next;
                        fail_mask[vec_idx] <= 1'b1;
                    end
                    if (abort) begin
                        state   <= S_IDLE;
                        pass    <= 1'b0;
                        vec_idx <= 2'd0;
                        dut_a   <= 1'b0;
                        dut_b   <= 1'b0;
                        cnt     <= 4'd0;
                    end else if (vec_idx == 2'd3) begin
                        state <= S_DONE;
                        // Use the post-update count so a last-vector mismatch clears pass.
                        pass  <= (err_next == 3'd0);
                    end else begin
                        vec_idx        <= vec_idx + 2'd1;
                        {dut_a, dut_b} <= vec_idx + 2'd1;
                        cnt            <= CNT_LOAD;
                        state          <= S_SETTLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Purpose : randomized self-checking bench for gate_test_sequencer against a vector-level model.
// Latency : model expects vector k/(S+1) in cycle k after start, done in cycle 4*(S+1).
// Backpr. : start noise during runs and in DONE must be ignored; abort and async reset exercised.
module tb_gate_test_sequencer;

    localparam logic [3:0] TT1 = 4'b1000;
    localparam int         S1  = 2;
    localparam logic [3:0] TT2 = 4'b0110;
    localparam int         S2  = 1;

    logic clk, rst;
    logic start, abort, dut_y, dut_a, dut_b, exp_y, busy, done, pass;
    logic [1:0] vec_idx;
    logic [2:0] err_count;
    logic [3:0] fail_mask;
    logic start2, abort2, dut_y2, dut_a2, dut_b2, exp_y2, busy2, done2, pass2;
    logic [1:0] vec_idx2;
    logic [2:0] err_count2;
    logic [3:0] fail_mask2;

    logic [3:0] gate_tt;   // behaviour of the emulated gate under test
    int tests = 0;
    int fails = 0;

    assign dut_y  = gate_tt[{dut_a, dut_b}];
    assign dut_y2 = dut_a2 ^ dut_b2;

    gate_test_sequencer #(.TT(TT1), .SETTLE(S1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_y(dut_y),
        .dut_a(dut_a), .dut_b(dut_b), .exp_y(exp_y), .vec_idx(vec_idx),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_mask(fail_mask)
    );

    gate_test_sequencer #(.TT(TT2), .SETTLE(S2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .dut_y(dut_y2),
        .dut_a(dut_a2), .dut_b(dut_b2), .exp_y(exp_y2), .vec_idx(vec_idx2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2), .fail_mask(fail_mask2)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({dut_a, dut_b, vec_idx, busy, done, pass, err_count, fail_mask} !== 14'd0) begin
            fails++;
            $display("FAIL reset_dut1 got=%b exp=0", {dut_a, dut_b, vec_idx, busy, done, pass, err_count, fail_mask});
        end
        tests++;
        if ({dut_a2, dut_b2, vec_idx2, busy2, done2, pass2, err_count2, fail_mask2} !== 14'd0) begin
            fails++;
            $display("FAIL reset_dut2 got=%b exp=0", {dut_a2, dut_b2, vec_idx2, busy2, done2, pass2, err_count2, fail_mask2});
        end
        rst = 1'b0;
    endtask

    // One full run on dut1 with gate behaviour g; the model derives the mismatch
    // set directly as g XOR TT and the vector schedule from the hold time.
    task automatic run_check(input string name, input logic [3:0] g, input bit noisy);
        logic [3:0] m;
        logic [2:0] e;
        logic [1:0] v;
        int len;
        len     = 4 * (S1 + 1);
        gate_tt = g;
        m       = g ^ TT1;
        e       = 3'($countones(m));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            v = 2'(k / (S1 + 1));
            tests++;
            if ({busy, done, dut_a, dut_b, vec_idx} !== {2'b10, v, v}) begin
                fails++;
                $display("FAIL %s seq k=%0d got=%b exp=%b", name, k, {busy, done, dut_a, dut_b, vec_idx}, {2'b10, v, v});
            end
            tests++;
            if (exp_y !== TT1[v]) begin
                fails++;
                $display("FAIL %s exp_y k=%0d got=%b exp=%b", name, k, exp_y, TT1[v]);
            end
            if (noisy) start = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        tests++;
        if ({busy, done, pass, err_count, fail_mask} !== {2'b01, (m == 4'd0), e, m}) begin
            fails++;
            $display("FAIL %s done got=%b exp=%b", name, {busy, done, pass, err_count, fail_mask}, {2'b01, (m == 4'd0), e, m});
        end
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if ({busy, done, pass, err_count, fail_mask, dut_a, dut_b} !== {2'b00, (m == 4'd0), e, m, 2'b11}) begin
            fails++;
            $display("FAIL %s hold got=%b exp=%b", name, {busy, done, pass, err_count, fail_mask, dut_a, dut_b}, {2'b00, (m == 4'd0), e, m, 2'b11});
        end
    endtask

    task automatic test_and_pass();
        run_check("and_pass", 4'b1000, 1'b0);
    endtask

    task automatic test_or_fail();
        run_check("or_fail", 4'b1110, 1'b0);
    endtask

    task automatic test_stuck_then_clean();
        run_check("stuck1", 4'b1111, 1'b0);
        run_check("clean_after_stuck", 4'b1000, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) run_check("random", 4'($urandom_range(0, 15)), 1'b1);
    endtask

    task automatic test_abort();
        logic [3:0] g, m;
        bit saw_done;
        g = 4'($urandom_range(0, 15));
        gate_tt = g;
        m = (g ^ TT1) & 4'b0011;   // only vectors 0 and 1 are checked before abort
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // Cycle 2*(S1+1) is the first SETTLE cycle of vector 2.
        repeat (2 * (S1 + 1) + 1) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, done, pass, dut_a, dut_b, vec_idx} !== 7'd0) begin
            fails++;
            $display("FAIL abort_state got=%b exp=0", {busy, done, pass, dut_a, dut_b, vec_idx});
        end
        tests++;
        if ({err_count, fail_mask} !== {3'($countones(m)), m}) begin
            fails++;
            $display("FAIL abort_partial got=%b exp=%b", {err_count, fail_mask}, {3'($countones(m)), m});
        end
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        tests++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done got=%b exp=0", saw_done);
        end
    endtask

    task automatic test_async_reset();
        gate_tt = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // Cycle 2*(S1+1)-1 is the CHECK cycle of vector 1.
        repeat (2 * (S1 + 1)) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({dut_a, dut_b, vec_idx, busy, done, pass, err_count, fail_mask} !== 14'd0) begin
            fails++;
            $display("FAIL async_reset got=%b exp=0", {dut_a, dut_b, vec_idx, busy, done, pass, err_count, fail_mask});
        end
        @(negedge clk);
        rst = 1'b0;
        run_check("after_reset", 4'b1000, 1'b0);
    endtask

    // Start held high: each run is 4*(S+1) busy cycles, one DONE cycle, one IDLE cycle.
    task automatic test_back_to_back();
        int period, ph, ndone;
        logic [1:0] v;
        period = 4 * (S2 + 1) + 2;
        ndone  = 0;
        @(negedge clk);
        start2 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            ph = k % period;
            v  = (ph < 4 * (S2 + 1)) ? 2'(ph / (S2 + 1)) : 2'd3;
            if (k == 29) start2 = 1'b0;
            if (done2) ndone++;
            tests++;
            if ({busy2, done2, dut_a2, dut_b2} !== {(ph < 4 * (S2 + 1)), (ph == 4 * (S2 + 1)), v}) begin
                fails++;
                $display("FAIL b2b k=%0d got=%b exp=%b", k, {busy2, done2, dut_a2, dut_b2}, {(ph < 4 * (S2 + 1)), (ph == 4 * (S2 + 1)), v});
            end
            if (ph == 4 * (S2 + 1)) begin
                tests++;
                if ({pass2, err_count2, fail_mask2} !== 8'b1000_0000) begin
                    fails++;
                    $display("FAIL b2b_pass k=%0d got=%b exp=10000000", k, {pass2, err_count2, fail_mask2});
                end
            end
        end
        tests++;
        if (ndone != 3) begin
            fails++;
            $display("FAIL b2b_done_count got=%0d exp=3", ndone);
        end
        repeat (3) @(negedge clk);
        tests++;
        if ({busy2, done2} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_idle got=%b exp=00", {busy2, done2});
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        gate_tt = 4'b1000;
        test_reset();
        test_and_pass();
        test_or_fail();
        test_stuck_then_clean();
        test_random();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
